pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Hazard, forwarding and sequencing controller for the 5-stage RISC-V pipeline.
//  - Drives the execute stage's operand-forwarding selects.
//  - Stalls IF/ID on load-use hazards; flushes IF/ID and ID/EX on a taken branch or jump.
//  - Sequences trap handling: drain the older instructions, halt, then resume on request.
// PARAMETERS
//  DRAIN_CYCLES  2   cycles spent in DRAIN (MEM + WB empty-out) before HALT
//  PERF_W        32  width of the performance counters (PERF_COUNTERS_EN only)
// PORTS
//  clk            in   1   clock
//  reset_n        in   1   synchronous, active-low reset
//  id_rs1_i       in   5   rs1 of the instruction in ID
//  id_rs2_i       in   5   rs2 of the instruction in ID
//  id_uses_rs1_i  in   1   ID instruction reads rs1
//  id_uses_rs2_i  in   1   ID instruction reads rs2
//  ex_rd_i        in   5   ID/EX rd
//  ex_use_mem_i   in   1   ID/EX instruction is a load
//  ex_write_reg_i in   1   ID/EX writes rd
//  mem_rd_i       in   5   EX/MEM rd
//  mem_write_i    in   1   EX/MEM writes rd
//  wb_rd_i        in   5   MEM/WB rd
//  wb_write_i     in   1   MEM/WB writes rd
//  pc_load_i      in   1   taken branch/jump resolved in EX
//  trap_ex_i      in   1   trap flag of the instruction in EX
//  resume_i       in   1   leave HALT (1-cycle pulse)
//  fwd_ex_mem_rs1_o / fwd_ex_mem_rs2_o  out  1  forward EX/MEM result to EX rs1 / rs2
//  fwd_mem_wb_rs1_o / fwd_mem_wb_rs2_o  out  1  forward MEM/WB result to EX rs1 / rs2
//  stall_if_o     out  1   hold PC
//  stall_id_o     out  1   hold IF/ID
//  flush_id_o     out  1   load a bubble into IF/ID
//  flush_ex_o     out  1   load a bubble into ID/EX
//  halted_o       out  1   FSM is in HALT
// BEHAVIOUR
//  - Shadow registers ex_rs1_q/ex_rs2_q (+ uses bits) track the rs fields of ID/EX.
//    - Load from the id_* inputs when not stalled; cleared to 0 on flush_ex_o.
//  - Forwarding (combinational from the shadow registers):
//    - EX/MEM select when mem_write_i && mem_rd_i != 0 && mem_rd_i == ex_rsN_q && uses.
//    - Otherwise MEM/WB select, under the same rule with the wb_* inputs.
//    - EX/MEM has priority over MEM/WB; rd == x0 never forwards.
//  - Load-use hazard:
//    - Condition: ex_use_mem_i && ex_write_reg_i && ex_rd_i != 0 && ex_rd_i matches a used id_rsN.
//    - Response: stall_if_o = stall_id_o = flush_ex_o = 1 for exactly 1 cycle.
//    - The next cycle the dependent instruction reaches EX and takes the MEM/WB forward.
//  - Taken branch (pc_load_i in RUN): flush_id_o = flush_ex_o = 1 and no stall.
//    - Overrides a simultaneous load-use stall.
//  - FSM, state register reset to RUN:
//    - RUN   -> DRAIN on trap_ex_i; flush_id_o = flush_ex_o = 1 that cycle.
//    - DRAIN: stall_if_o = stall_id_o = flush_ex_o = 1; counter loads DRAIN_CYCLES-1 and
//      counts down; leaves for HALT on 0. trap_ex_i / pc_load_i are ignored here.
//    - HALT: stall_if_o = stall_id_o = flush_ex_o = 1, halted_o = 1.
//      On resume_i: flush_id_o = 1, go to RUN.
//    - trap_ex_i and pc_load_i in the same cycle: trap wins (DRAIN).
//  - Reset values:
//    - All outputs 0; halted_o = 0; shadow registers 0; counters 0.
//    - Reset mid-DRAIN/HALT returns to RUN.
// CONFIGURATION
//  - PERF_COUNTERS_EN defined: adds outputs perf_stall_o[PERF_W] and perf_flush_o[PERF_W].
//    - perf_stall_o counts load-use stall cycles; perf_flush_o counts taken-branch flushes.
//    - Both wrap modulo 2^PERF_W and are cleared by reset.
//  - PERF_COUNTERS_EN not defined: these ports and counters do not exist.
// STRUCTURE
//  - definitions.vh gains the FSM state encodings (CTRL_RUN, CTRL_DRAIN, CTRL_HALT) and
//    the x0 index constant.
//  - Sub-module fwd_match: one per rs operand; takes rs, uses, both rd/write pairs;
//    returns the two select bits.
// TESTING
//  - Forwarding priority: ADD x5; ADD x5; ADD x6,x5,x5 -> third op sees
//    fwd_ex_mem_rs1/rs2 = 1 and MEM/WB = 0.
//  - Load-use: LW x7; ADD x8,x7,x1 -> exactly 1 cycle of stall_if/stall_id/flush_ex,
//    then fwd_mem_wb_rs1 = 1.
//  - x0 destination: LW x0; ADD x1,x0,x0 -> no stall, no forward.
//  - Branch vs load-use: pc_load_i with a load-use hazard in the same cycle ->
//    flush_id = flush_ex = 1, stall_if = 0.
//  - Trap: trap_ex_i at cycle T -> halted_o = 1 at T+1+DRAIN_CYCLES;
//    resume_i -> flush_id for 1 cycle, then normal flow.
//  - Reset during HALT -> halted_o = 0 and all stall/flush outputs 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: register index width, the x0
// index and the sequencing FSM state encodings.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_DRAIN = 2'd1,
    CTRL_HALT  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_fwd_match.sv
// Forwarding select for one EX operand: EX/MEM beats MEM/WB, and x0 never forwards.
module pipeline_ctrl_fwd_match
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_uses,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_write,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_write,
  output logic             o_sel_ex_mem,
  output logic             o_sel_mem_wb
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_uses && i_mem_write && (i_mem_rd != X0) && (i_mem_rd == i_rs);
  assign w_wb_hit  = i_uses && i_wb_write  && (i_wb_rd  != X0) && (i_wb_rd  == i_rs);

  assign o_sel_ex_mem = w_mem_hit;
  assign o_sel_mem_wb = w_wb_hit && !w_mem_hit;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and trap-sequencing controller for the 5-stage pipeline.
// Optional performance counters are built when PERF_COUNTERS_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
`ifdef PERF_COUNTERS_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_use_mem_i,
  input  logic             ex_write_reg_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_write_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_write_i,
  input  logic             pc_load_i,
  input  logic             trap_ex_i,
  input  logic             resume_i,
  output logic             fwd_ex_mem_rs1_o,
  output logic             fwd_ex_mem_rs2_o,
  output logic             fwd_mem_wb_rs1_o,
  output logic             fwd_mem_wb_rs2_o,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             halted_o,
  output logic [1:0]       dbg_state_o
`ifdef PERF_COUNTERS_EN
  , output logic [PERF_W-1:0] perf_stall_o,
  output logic [PERF_W-1:0] perf_flush_o
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic [REG_W-1:0] r_ex_rs1, r_ex_rs2;
  logic             r_ex_uses_rs1, r_ex_uses_rs2;
  logic             w_load_use;
  logic             w_stall, w_flush_id, w_flush_ex, w_halted;
  logic             w_em_rs1, w_em_rs2, w_mw_rs1, w_mw_rs2;

  assign w_load_use = ex_use_mem_i && ex_write_reg_i && (ex_rd_i != X0) &&
                      ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  // Priority in RUN: trap, then taken branch, then load-use stall.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_stall         = 1'b0;
    w_flush_id      = 1'b0;
    w_flush_ex      = 1'b0;
    w_halted        = 1'b0;
    case (r_state)
      CTRL_RUN: begin
        if (trap_ex_i) begin
          w_state_nxt     = CTRL_DRAIN;
          w_drain_cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
          w_flush_id      = 1'b1;
          w_flush_ex      = 1'b1;
        end else if (pc_load_i) begin
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
        end else if (w_load_use) begin
          w_stall    = 1'b1;
          w_flush_ex = 1'b1;
        end
      end
      CTRL_DRAIN: begin
        w_stall    = 1'b1;
        w_flush_ex = 1'b1;
        if (r_drain_cnt == '0) w_state_nxt = CTRL_HALT;
        else                   w_drain_cnt_nxt = r_drain_cnt - CNT_W'(1);
      end
      CTRL_HALT: begin
        w_stall    = 1'b1;
        w_flush_ex = 1'b1;
        w_halted   = 1'b1;
        if (resume_i) begin
          w_flush_id  = 1'b1;
          w_state_nxt = CTRL_RUN;
        end
      end
      default: w_state_nxt = CTRL_RUN;
    endcase
  end

  // Shadow rs fields mirror the ID/EX register: a bubble clears them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= CTRL_RUN;
      r_drain_cnt   <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_uses_rs1 <= 1'b0;
      r_ex_uses_rs2 <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      if (w_flush_ex) begin
        r_ex_rs1      <= '0;
        r_ex_rs2      <= '0;
        r_ex_uses_rs1 <= 1'b0;
        r_ex_uses_rs2 <= 1'b0;
      end else if (!w_stall) begin
        r_ex_rs1      <= id_rs1_i;
        r_ex_rs2      <= id_rs2_i;
        r_ex_uses_rs1 <= id_uses_rs1_i;
        r_ex_uses_rs2 <= id_uses_rs2_i;
      end
    end
  end

  pipeline_ctrl_fwd_match u_fwd_rs1 (
    .i_rs         (r_ex_rs1),
    .i_uses       (r_ex_uses_rs1),
    .i_mem_rd     (mem_rd_i),
    .i_mem_write  (mem_write_i),
    .i_wb_rd      (wb_rd_i),
    .i_wb_write   (wb_write_i),
    .o_sel_ex_mem (w_em_rs1),
    .o_sel_mem_wb (w_mw_rs1)
  );

  pipeline_ctrl_fwd_match u_fwd_rs2 (
    .i_rs         (r_ex_rs2),
    .i_uses       (r_ex_uses_rs2),
    .i_mem_rd     (mem_rd_i),
    .i_mem_write  (mem_write_i),
    .i_wb_rd      (wb_rd_i),
    .i_wb_write   (wb_write_i),
    .o_sel_ex_mem (w_em_rs2),
    .o_sel_mem_wb (w_mw_rs2)
  );

  // Outputs are held low while reset is asserted.
  assign fwd_ex_mem_rs1_o = reset_n && w_em_rs1;
  assign fwd_ex_mem_rs2_o = reset_n && w_em_rs2;
  assign fwd_mem_wb_rs1_o = reset_n && w_mw_rs1;
  assign fwd_mem_wb_rs2_o = reset_n && w_mw_rs2;
  assign stall_if_o       = reset_n && w_stall;
  assign stall_id_o       = reset_n && w_stall;
  assign flush_id_o       = reset_n && w_flush_id;
  assign flush_ex_o       = reset_n && w_flush_ex;
  assign halted_o         = reset_n && w_halted;
  assign dbg_state_o      = r_state;

`ifdef PERF_COUNTERS_EN
  logic              w_ld_stall_evt, w_br_flush_evt;
  logic [PERF_W-1:0] r_perf_stall, r_perf_flush;

  assign w_ld_stall_evt = (r_state == CTRL_RUN) && !trap_ex_i && !pc_load_i && w_load_use;
  assign w_br_flush_evt = (r_state == CTRL_RUN) && !trap_ex_i && pc_load_i;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_ld_stall_evt) r_perf_stall <= r_perf_stall + PERF_W'(1);
      if (w_br_flush_evt) r_perf_flush <= r_perf_flush + PERF_W'(1);
    end
  end

  assign perf_stall_o = r_perf_stall;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule
